// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI bus master: state encoding and default phase lengths.
// Used by hpi_bus_master and its sub-modules via import hpi_pkg::*.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } hpi_state_e;

  localparam int unsigned HPI_T_SETUP_DEF   = 2;
  localparam int unsigned HPI_T_STROBE_DEF  = 2;
  localparam int unsigned HPI_T_HOLD_DEF    = 2;
  localparam int unsigned HPI_T_RECOVER_DEF = 2;

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hpi_irq_sync.sv
// Two-flop synchroniser for the HPI interrupt line with a registered rising-edge pulse.
// The edge history reads as 1 until the synchroniser has filled, so a line already high at reset never pulses.
module hpi_irq_sync (
  input  logic clk,
  input  logic resetn,
  input  logic irq_async,
  output logic irq_pulse
);

  logic [1:0] sync_q;
  logic [1:0] armed_q;
  logic       prev_q;
  logic       pulse_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      armed_q <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], irq_async};
      armed_q <= {armed_q[0], 1'b1};
      prev_q  <= armed_q[1] ? sync_q[1] : 1'b1;
      pulse_q <= armed_q[1] & sync_q[1] & ~prev_q;
    end
  end

  assign irq_pulse = pulse_q;

endmodule

// File: rtl/hpi_bus_master.sv
// HPI bus master: sequences SETUP/STROBE/HOLD/RECOVER phases for single reads/writes.
// Define HPI_BURST_EN to allow multi-beat reads of req_len+1 beats; otherwise req_len is ignored.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned T_SETUP   = HPI_T_SETUP_DEF,
  parameter int unsigned T_STROBE  = HPI_T_STROBE_DEF,
  parameter int unsigned T_HOLD    = HPI_T_HOLD_DEF,
  parameter int unsigned T_RECOVER = HPI_T_RECOVER_DEF,
  parameter int unsigned LEN_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_port,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic              hpi_csn,
  output logic              hpi_oen,
  output logic              hpi_wen,
  output logic [ADDR_W-1:0] hpi_address,
  output logic [DATA_W-1:0] hpi_data_o,
  output logic              hpi_data_oe,
  input  logic [DATA_W-1:0] hpi_data_i,
  input  logic              hpi_irq,
  output logic              irq_pulse
);

`ifdef HPI_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam int unsigned T_MAX = max_of4(T_SETUP, T_STROBE, T_HOLD, T_RECOVER);
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

  hpi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  phase_cnt;
  logic              phase_end;
  logic              started_q;
  logic              accept;
  logic              last_beat;
  logic              active;
  logic [ADDR_W-1:0] port_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [DATA_W-1:0] rdata_q;

  assign req_ready = started_q && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign last_beat = !BURST_EN || write_q || (beat_q == len_q);

  always_comb begin
    state_d   = state_q;
    phase_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        phase_end = (phase_cnt == CNT_W'(T_SETUP - 1));
        if (phase_end) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        phase_end = (phase_cnt == CNT_W'(T_STROBE - 1));
        if (phase_end) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        phase_end = (phase_cnt == CNT_W'(T_HOLD - 1));
        if (phase_end) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        phase_end = (phase_cnt == CNT_W'(T_RECOVER - 1));
        if (phase_end) state_d = last_beat ? ST_IDLE : ST_SETUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      phase_cnt <= '0;
      started_q <= 1'b0;
      port_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      rdata_q   <= '0;
    end else begin
      started_q <= 1'b1;
      state_q   <= state_d;
      if (state_q == ST_IDLE || phase_end) phase_cnt <= '0;
      else phase_cnt <= phase_cnt + 1'b1;
      if (accept) begin
        port_q  <= req_port;
        write_q <= req_write;
        wdata_q <= req_wdata;
        len_q   <= req_len;
        beat_q  <= '0;
      end
      // Read data is captured on the edge that closes the last STROBE cycle.
      if (state_q == ST_STROBE && phase_end) rdata_q <= write_q ? '0 : hpi_data_i;
      if (state_q == ST_RECOVER && phase_end && !last_beat) beat_q <= beat_q + 1'b1;
    end
  end

  assign active      = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign hpi_csn     = !active;
  assign hpi_oen     = !((state_q == ST_STROBE) && !write_q);
  assign hpi_wen     = !((state_q == ST_STROBE) && write_q);
  assign hpi_data_oe = active && write_q;
  assign hpi_data_o  = hpi_data_oe ? wdata_q : '0;
  assign hpi_address = port_q;
  assign rsp_valid   = (state_q == ST_HOLD) && (phase_cnt == '0);
  assign rsp_rdata   = rdata_q;
  assign rsp_last    = rsp_valid && last_beat;

  hpi_irq_sync u_irq_sync (
    .clk       (clk),
    .resetn    (resetn),
    .irq_async (hpi_irq),
    .irq_pulse (irq_pulse)
  );

endmodule
